// File: rtl/quire_pkg.sv
// quire_pkg: sizing helpers shared by the quire, the normaliser and the
// posit encoder, plus the normalised-result record for the default
// configuration (16-bit posit, es=1, 15 carry-guard bits).
package quire_pkg;

    localparam int POSIT_WIDTH_DEF  = 16;
    localparam int POSIT_ES_DEF     = 1;
    localparam int LOG_NB_ACCUM_DEF = 15;

    // Total quire width: integer and fraction ranges, sign and carry guard.
    function automatic int calc_qs(input int w, input int es, input int lnb);
        return (2 ** (es + 2)) * (w - 2) + 1 + lnb;
    endfunction

    // Number of quire bits below the binary point.
    function automatic int calc_bpp(input int w, input int es);
        return (2 ** (es + 1)) * (w - 2);
    endfunction

    // Signed scale width able to hold any floor(log2|q|).
    function automatic int calc_sw(input int qs);
        return $clog2(qs) + 1;
    endfunction

    localparam int QS_DEF   = calc_qs(POSIT_WIDTH_DEF, POSIT_ES_DEF, LOG_NB_ACCUM_DEF);
    localparam int BPP_DEF  = calc_bpp(POSIT_WIDTH_DEF, POSIT_ES_DEF);
    localparam int SW_DEF   = calc_sw(QS_DEF);
    localparam int FRAC_DEF = POSIT_WIDTH_DEF - POSIT_ES_DEF - 3;

    typedef struct packed {
        logic                     sign;
        logic                     zero;
        logic                     NaR;
        logic signed [SW_DEF-1:0] scale;
        logic [FRAC_DEF-1:0]      fraction;
        logic                     guard;
        logic                     sticky;
    } norm_out_t;

endpackage

// File: rtl/quire_normalize_lzc.sv
// lzc: parameterised leading-zero counter. count_o equals WIDTH when the
// input is all zeros, which zero_o also flags.
module lzc #(
    parameter int  WIDTH = 128,
    localparam int CW    = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] data_i,
    output logic [CW-1:0]    count_o,
    output logic             zero_o
);

    // Scan upward so the highest set bit is the last one to write the count.
    always_comb begin
        count_o = CW'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (data_i[i]) begin
                count_o = CW'(WIDTH - 1 - i);
            end
        end
    end

    assign zero_o = ~|data_i;

endmodule

// File: rtl/quire_normalize.sv
// quire_normalize: turns the two's-complement quire into sign, unbiased
// scale, truncated fraction and guard/sticky for the posit encoder.
// rts/rtr handshake, single-entry skid latch, 3-stage pipeline:
//   stage 1: sign and magnitude
//   stage 2: leading-zero count and zero detect
//   stage 3: normalising shift, field extraction, special cases
// Build option QUIRE_NORMALIZE_EOW_ONLY_EN: only beats carrying eow are
// forwarded; the rest are consumed and dropped at stage 1.
module quire_normalize
    import quire_pkg::*;
#(
    parameter int  POSIT_WIDTH    = 16,
    parameter int  POSIT_ES       = 1,
    parameter int  LOG_NB_ACCUM   = 15,
    parameter int  FRAC_OUT_WIDTH = POSIT_WIDTH - POSIT_ES - 3,
    localparam int QS             = calc_qs(POSIT_WIDTH, POSIT_ES, LOG_NB_ACCUM),
    localparam int BPP            = calc_bpp(POSIT_WIDTH, POSIT_ES),
    localparam int SW             = calc_sw(QS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      rts_i,
    output logic                      rtr_o,
    input  logic                      sow_i,
    input  logic                      eow_i,
    input  logic [QS-1:0]             data_i,
    input  logic                      NaR_i,
    output logic                      rts_o,
    input  logic                      rtr_i,
    output logic                      sow_o,
    output logic                      eow_o,
    output logic                      sign_o,
    output logic                      zero_o,
    output logic                      NaR_o,
    output logic signed [SW-1:0]      scale_o,
    output logic [FRAC_OUT_WIDTH-1:0] fraction_o,
    output logic                      guard_o,
    output logic                      sticky_o
);

    localparam int F  = FRAC_OUT_WIDTH;
    localparam int CW = $clog2(QS) + 1;
    // Normalised word without its leading one, padded so fraction and guard
    // always exist even when the quire is narrower than the output fields.
    localparam int EW = QS + F + 1;

`ifdef QUIRE_NORMALIZE_EOW_ONLY_EN
    localparam bit EOW_ONLY = 1'b1;
`else
    localparam bit EOW_ONLY = 1'b0;
`endif

    // handshake and skid latch
    logic          process_en;
    logic          receive_en;
    logic          rtr_q;
    logic          latched_q;
    logic [QS-1:0] lat_data_q;
    logic          lat_nar_q;
    logic          lat_sow_q;
    logic          lat_eow_q;

    // stage-1 input selection
    logic          in_valid;
    logic          in_keep;
    logic [QS-1:0] in_data;
    logic          in_nar;
    logic          in_sow;
    logic          in_eow;
    logic          in_sign;
    logic [QS-1:0] in_mag;

    logic [2:0]    staged_q;
    logic [2:0]    stage_en;
    logic [2:0]    stage_clr;

    // stage 1 registers
    logic          s1_sign_q;
    logic [QS-1:0] s1_mag_q;
    logic          s1_nar_q;
    logic          s1_sow_q;
    logic          s1_eow_q;

    // stage 2 registers
    logic          s2_sign_q;
    logic [QS-1:0] s2_mag_q;
    logic [CW-1:0] s2_lz_q;
    logic          s2_zero_q;
    logic          s2_nar_q;
    logic          s2_sow_q;
    logic          s2_eow_q;
    logic [CW-1:0] lz_d;
    logic          zero_d;

    // stage 3 (output) registers
    logic          out_sign_q;
    logic          out_zero_q;
    logic          out_nar_q;
    logic signed [SW-1:0] out_scale_q;
    logic [F-1:0]  out_frac_q;
    logic          out_guard_q;
    logic          out_sticky_q;
    logic          out_sow_q;
    logic          out_eow_q;

    // stage 3 combinational
    logic [QS-1:0] norm;
    logic [EW-1:0] ext;
    logic signed [SW-1:0] scale_d;
    logic [F-1:0]  frac_d;
    logic          guard_d;
    logic          sticky_d;

    assign process_en = rtr_i | ~staged_q[2];
    assign receive_en = rts_i & rtr_q;

    // Stage 1 source: a held beat always drains before anything new.
    always_comb begin
        in_valid = latched_q | receive_en;
        in_data  = latched_q ? lat_data_q : data_i;
        in_nar   = latched_q ? lat_nar_q  : NaR_i;
        in_sow   = latched_q ? lat_sow_q  : sow_i;
        in_eow   = latched_q ? lat_eow_q  : eow_i;
        in_keep  = in_valid & (~EOW_ONLY | in_eow);
        in_sign  = in_data[QS-1];
        in_mag   = in_sign ? (~in_data + QS'(1)) : in_data;
    end

    // Whole-pipeline advance: each stage loads when its source holds a beat,
    // otherwise its valid bit is cleared while its data registers keep value.
    always_comb begin
        stage_en[0]  = process_en & in_keep;
        stage_clr[0] = process_en & ~in_keep;
        stage_en[1]  = process_en & staged_q[0];
        stage_clr[1] = process_en & ~staged_q[0];
        stage_en[2]  = process_en & staged_q[1];
        stage_clr[2] = process_en & ~staged_q[1];
    end

    // Registered ready, skid latch capture/drain and per-stage valid bits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rtr_q      <= 1'b0;
            latched_q  <= 1'b0;
            lat_data_q <= '0;
            lat_nar_q  <= 1'b0;
            lat_sow_q  <= 1'b0;
            lat_eow_q  <= 1'b0;
            staged_q   <= '0;
        end else begin
            rtr_q <= process_en;
            if (receive_en && !process_en) begin
                latched_q  <= 1'b1;
                lat_data_q <= data_i;
                lat_nar_q  <= NaR_i;
                lat_sow_q  <= sow_i;
                lat_eow_q  <= eow_i;
            end else if (process_en) begin
                latched_q <= 1'b0;
            end
            for (int k = 0; k < 3; k++) begin
                if (stage_en[k]) begin
                    staged_q[k] <= 1'b1;
                end else if (stage_clr[k]) begin
                    staged_q[k] <= 1'b0;
                end
            end
        end
    end

    // Stage 1: sign and magnitude; the most negative quire maps to 2^(QS-1).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_sign_q <= 1'b0;
            s1_mag_q  <= '0;
            s1_nar_q  <= 1'b0;
            s1_sow_q  <= 1'b0;
            s1_eow_q  <= 1'b0;
        end else if (stage_en[0]) begin
            s1_sign_q <= in_sign;
            s1_mag_q  <= in_mag;
            s1_nar_q  <= in_nar;
            s1_sow_q  <= in_sow;
            s1_eow_q  <= in_eow;
        end
    end

    lzc #(
        .WIDTH (QS)
    ) u_lzc (
        .data_i  (s1_mag_q),
        .count_o (lz_d),
        .zero_o  (zero_d)
    );

    // Stage 2: leading-zero count and zero detect.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_sign_q <= 1'b0;
            s2_mag_q  <= '0;
            s2_lz_q   <= '0;
            s2_zero_q <= 1'b0;
            s2_nar_q  <= 1'b0;
            s2_sow_q  <= 1'b0;
            s2_eow_q  <= 1'b0;
        end else if (stage_en[1]) begin
            s2_sign_q <= s1_sign_q;
            s2_mag_q  <= s1_mag_q;
            s2_lz_q   <= lz_d;
            s2_zero_q <= zero_d;
            s2_nar_q  <= s1_nar_q;
            s2_sow_q  <= s1_sow_q;
            s2_eow_q  <= s1_eow_q;
        end
    end

    // Normalise so the leading one sits at QS-1, then slice the fields
    // from the bits below it.
    always_comb begin
        norm     = s2_mag_q << s2_lz_q;
        ext      = {norm[QS-2:0], {(F + 2){1'b0}}};
        frac_d   = ext[QS+F -: F];
        guard_d  = ext[QS];
        sticky_d = |ext[QS-1:0];
        scale_d  = SW'(QS - 1 - BPP) - SW'(s2_lz_q);
    end

    // Stage 3: output registers with NaR and zero forcing the fields to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_sign_q   <= 1'b0;
            out_zero_q   <= 1'b0;
            out_nar_q    <= 1'b0;
            out_scale_q  <= '0;
            out_frac_q   <= '0;
            out_guard_q  <= 1'b0;
            out_sticky_q <= 1'b0;
            out_sow_q    <= 1'b0;
            out_eow_q    <= 1'b0;
        end else if (stage_en[2]) begin
            out_sow_q <= s2_sow_q;
            out_eow_q <= s2_eow_q;
            if (s2_nar_q) begin
                out_sign_q   <= 1'b0;
                out_zero_q   <= 1'b0;
                out_nar_q    <= 1'b1;
                out_scale_q  <= '0;
                out_frac_q   <= '0;
                out_guard_q  <= 1'b0;
                out_sticky_q <= 1'b0;
            end else if (s2_zero_q) begin
                out_sign_q   <= 1'b0;
                out_zero_q   <= 1'b1;
                out_nar_q    <= 1'b0;
                out_scale_q  <= '0;
                out_frac_q   <= '0;
                out_guard_q  <= 1'b0;
                out_sticky_q <= 1'b0;
            end else begin
                out_sign_q   <= s2_sign_q;
                out_zero_q   <= 1'b0;
                out_nar_q    <= 1'b0;
                out_scale_q  <= scale_d;
                out_frac_q   <= frac_d;
                out_guard_q  <= guard_d;
                out_sticky_q <= sticky_d;
            end
        end
    end

    assign rtr_o      = rtr_q;
    assign rts_o      = staged_q[2];
    assign sow_o      = out_sow_q;
    assign eow_o      = out_eow_q;
    assign sign_o     = out_sign_q;
    assign zero_o     = out_zero_q;
    assign NaR_o      = out_nar_q;
    assign scale_o    = out_scale_q;
    assign fraction_o = out_frac_q;
    assign guard_o    = out_guard_q;
    assign sticky_o   = out_sticky_q;

endmodule
